irq_cause_sink: RTL and testbench
=================================

# irq_cause_sink

Receiving end of the interrupt-cause interface: samples `io_irq` / `io_irq_cause[5:0]` from an interrupt source block and queues each new interrupt event for the consuming core. Each entry is delivered through a valid/ready dequeue port. Rising edges of `io_irq` are events; a held level never produces more than one event. A sticky overflow flag reports events dropped when the queue is full. The block sits between interrupt source wrappers and the core's trap/cause register logic.

## Interface
- `DEPTH`, 4 — queue entries; power of two, ≥2
- `CAUSE_W`, 6 — cause width; bit 5 = external-source flag, bits 4:0 = cause code
- `clk`  in  1  — single clock
- `reset`  in  1  — asynchronous, active-low; all state cleared while low
- `io_irq`  in  1  — interrupt request level from source
- `io_irq_cause`  in  CAUSE_W  — cause accompanying `io_irq`, valid whenever `io_irq`=1
- `io_deq_valid`  out  1  — head entry available
- `io_deq_bits`  out  CAUSE_W  — head cause
- `io_deq_ext`  out  1  — copy of `io_deq_bits[5]`
- `io_deq_ready`  in  1  — consumer accepts head
- `io_count`  out  log2(DEPTH)+1  — entries held
- `io_overflow`  out  1  — sticky: an event was dropped
- `io_clr_overflow`  in  1  — clears `io_overflow`

## Operation
- Edge detect: `irq_q` registers `io_irq`. `event = io_irq & ~irq_q`.
- `irq_q` resets to 1. An `io_irq` level held high through reset release therefore produces no event until it falls and rises again.
- Enqueue: on `event`, push `io_irq_cause` into the circular buffer at `wr_ptr`. Pointers are log2(DEPTH)+1 bits wide; full/empty is decided by the MSB-differs compare.
- Dequeue: the transfer fires when `io_deq_valid & io_deq_ready`; `rd_ptr` advances.
- Full with a simultaneous dequeue: the event is accepted, `count` stays at DEPTH, and there is no overflow.
- Full without a dequeue: the event is dropped, `io_overflow` is set, and the buffer is unchanged.
- Overflow flag: set on a dropped event; cleared by `io_clr_overflow`. If set and clear happen in the same cycle, set wins.
- `io_count` = `wr_ptr - rd_ptr`, range 0..DEPTH.
- Entries are never merged or reordered; the queue is strict FIFO.
- Reset value of every output: `io_deq_valid`=0, `io_deq_bits`=0, `io_deq_ext`=0, `io_count`=0, `io_overflow`=0.
- Reset mid-operation: all queued entries are discarded immediately (asynchronous); pointers go to 0 and `irq_q` goes to 1.

## Timing
- Event to `io_deq_valid`: 1 cycle. The event is sampled at edge N and becomes visible after that edge; there is no combinational bypass from `io_irq` to `io_deq_*`.
- `io_deq_bits`, `io_deq_ext` and `io_count` are combinational from registered state only. They have no path from `io_deq_ready`.
- `io_deq_valid` does not depend on `io_deq_ready`. Once valid, `io_deq_bits` holds stable until the transfer fires.
- Throughput: one enqueue and one dequeue per cycle. Back-to-back events need `io_irq` to toggle, so one event per 2 cycles is the maximum from a single source.
- Overflow is visible the cycle after the dropped event.

## Structure
- Shared package holds:
  - `IRQ_CAUSE_W` = 6
  - `IRQ_EXT_BIT` = 5
  - `IRQ_CODE_W` = 5
  - a cause typedef {ext, code[4:0]}, reused by the source side.
- One sub-module: `irq_cause_fifo`, a generic DEPTH×CAUSE_W circular buffer with enq/deq/count/full/empty.
- Edge detect, overflow logic and `io_deq_ext` stay in the top level.

## Test plan
- Single event: pulse `io_irq` with cause 6'h22, `io_deq_ready`=0. Next cycle `io_deq_valid`=1, `io_deq_bits`=6'h22, `io_deq_ext`=1, `io_count`=1. Holding `io_irq` high adds nothing.
- Reset with irq high: hold `io_irq`=1 across reset deassertion. Expect no event and `io_count`=0. Drop then raise `io_irq` with cause 6'h02, then expect exactly one entry 6'h02 with `io_deq_ext`=0.
- Fill/overflow (DEPTH=4): five rising edges with causes 1,2,3,4,5 and ready=0. After the 4th, `io_count`=4. The 5th is dropped and `io_overflow`=1. Draining yields 1,2,3,4 in order.
- Full + simultaneous dequeue: with the queue full (1..4), pulse cause 6'h05 in the same cycle as ready=1. Expect `io_count` to stay 4, `io_overflow`=0, and a later drain of 2,3,4,5.
- Overflow set/clear race: assert `io_clr_overflow` in the same cycle as a dropped event, and expect `io_overflow`=1. Clearing alone on the next cycle gives 0.
- Async reset mid-drain: with 3 entries queued and ready=1, pull `reset` low between clock edges. Outputs drop to 0 immediately, and after release `io_count`=0.

Source files
------------

// File: rtl/irq_cause_sink_pkg.sv
// Shared definitions for the interrupt-cause interface, used by both the
// source wrappers and the sink side.
package irq_cause_sink_pkg;

    localparam int IRQ_CAUSE_W = 6;
    localparam int IRQ_EXT_BIT = 5;
    localparam int IRQ_CODE_W  = 5;

    typedef struct packed {
        logic                  ext;
        logic [IRQ_CODE_W-1:0] code;
    } irq_cause_t;

endpackage

// File: rtl/irq_cause_fifo.sv
// Generic DEPTH x W circular buffer.
// Pointers carry one extra wrap bit, which distinguishes full from empty.
module irq_cause_fifo
    import irq_cause_sink_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = IRQ_CAUSE_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enq,
    input  logic [W-1:0]             enq_data,
    input  logic                     deq,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (deq) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset; the head is masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (enq) mem[wr_ptr[AW-1:0]] <= enq_data;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/irq_cause_sink.sv
// Receiving end of the interrupt-cause interface: turns rising edges of
// io_irq into queued cause entries, delivered over a valid/ready port.
module irq_cause_sink
    import irq_cause_sink_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int CAUSE_W = IRQ_CAUSE_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    io_irq,
    input  logic [CAUSE_W-1:0]      io_irq_cause,
    output logic                    io_deq_valid,
    output logic [CAUSE_W-1:0]      io_deq_bits,
    output logic                    io_deq_ext,
    input  logic                    io_deq_ready,
    output logic [$clog2(DEPTH):0]  io_count,
    output logic                    io_overflow,
    input  logic                    io_clr_overflow
);

    // Dequeue handshake: a transfer happens on a clock edge where
    // io_deq_valid and io_deq_ready are both high; valid never looks at ready.
    logic irq_q;
    logic irq_event;
    logic deq_fire;
    logic enq;
    logic drop;
    logic full;
    logic empty;

    // irq_q resets high so a level already asserted at reset release is not an event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q       <= 1'b1;
            io_overflow <= 1'b0;
        end else begin
            irq_q <= io_irq;
            if (drop)                 io_overflow <= 1'b1;
            else if (io_clr_overflow) io_overflow <= 1'b0;
        end
    end

    assign irq_event = io_irq & ~irq_q;
    assign deq_fire  = io_deq_valid & io_deq_ready;
    // A full buffer still accepts an event when the head leaves in the same cycle.
    assign enq       = irq_event & (~full | deq_fire);
    assign drop      = irq_event & full & ~deq_fire;

    irq_cause_fifo #(
        .DEPTH (DEPTH),
        .W     (CAUSE_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .enq      (enq),
        .enq_data (io_irq_cause),
        .deq      (deq_fire),
        .head     (io_deq_bits),
        .count    (io_count),
        .full     (full),
        .empty    (empty)
    );

    assign io_deq_valid = ~empty;
    assign io_deq_ext   = io_deq_bits[IRQ_EXT_BIT];

endmodule

// File: tb/tb_irq_cause_sink.sv
// Self-checking bench for irq_cause_sink against a queue-based reference of
// the interrupt-event rules.
module tb_irq_cause_sink;

    localparam int DEPTH = 4;
    localparam int CW    = 6;

    logic          clk;
    logic          reset;
    logic          io_irq;
    logic [CW-1:0] io_irq_cause;
    logic          io_deq_valid;
    logic [CW-1:0] io_deq_bits;
    logic          io_deq_ext;
    logic          io_deq_ready;
    logic [2:0]    io_count;
    logic          io_overflow;
    logic          io_clr_overflow;

    int n_vec;
    int n_bad;

    // Reference: FIFO of causes, last sampled irq level, sticky overflow.
    logic [CW-1:0] exp_q[$];
    logic          m_irq_prev;
    logic          m_ov;

    irq_cause_sink #(.DEPTH(DEPTH), .CAUSE_W(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .io_irq          (io_irq),
        .io_irq_cause    (io_irq_cause),
        .io_deq_valid    (io_deq_valid),
        .io_deq_bits     (io_deq_bits),
        .io_deq_ext      (io_deq_ext),
        .io_deq_ready    (io_deq_ready),
        .io_count        (io_count),
        .io_overflow     (io_overflow),
        .io_clr_overflow (io_clr_overflow)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_irq_prev = 1'b1;
        m_ov       = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, 32'(io_deq_valid), 0);
        check({tag, "_bits"},  32'(io_deq_bits),  0);
        check({tag, "_ext"},   32'(io_deq_ext),   0);
        check({tag, "_count"}, 32'(io_count),     0);
        check({tag, "_ovf"},   32'(io_overflow),  0);
    endtask

    // Reset asserted between clock edges, released on a later falling edge.
    task automatic do_reset(input string tag);
        reset = 1'b0;
        #2;
        model_reset();
        check_zero_outputs(tag);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One clock cycle: drive at the falling edge, check, then advance the model.
    task automatic cyc(input logic irq, input logic [CW-1:0] cause,
                       input logic rdy, input logic clr);
        logic ev;
        logic fire;
        int   sz;
        io_irq          = irq;
        io_irq_cause    = cause;
        io_deq_ready    = rdy;
        io_clr_overflow = clr;
        #1;
        sz = exp_q.size();
        check("valid", 32'(io_deq_valid), 32'(sz > 0));
        check("count", 32'(io_count), 32'(sz));
        check("ovf",   32'(io_overflow), 32'(m_ov));
        if (sz > 0) begin
            check("bits", 32'(io_deq_bits), 32'(exp_q[0]));
            check("ext",  32'(io_deq_ext),  32'(exp_q[0][5]));
        end
        @(posedge clk);
        ev   = irq & ~m_irq_prev;
        fire = (sz > 0) & rdy;
        if (fire) void'(exp_q.pop_front());
        if (ev && (sz < DEPTH || fire)) exp_q.push_back(cause);
        if (ev && sz == DEPTH && !fire) m_ov = 1'b1;
        else if (clr)                   m_ov = 1'b0;
        m_irq_prev = irq;
        @(negedge clk);
    endtask

    task automatic push(input logic [CW-1:0] cause);
        cyc(1'b1, cause, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset = 1'b0;
        io_irq = 1'b0;
        io_irq_cause = '0;
        io_deq_ready = 1'b0;
        io_clr_overflow = 1'b0;
        model_reset();
        @(negedge clk);
        check_zero_outputs("reset");
        @(negedge clk);
        reset = 1'b1;

        // Single event, then a held level adds nothing.
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b1, 6'h22, 1'b0, 1'b0);
        check("single_bits", 32'(io_deq_bits), 32'h22);
        check("single_ext",  32'(io_deq_ext), 1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 6'h22, 1'b0, 1'b0);
        check("held_count", 32'(io_count), 1);
        drain();

        // Level held high across reset release.
        io_irq = 1'b1;
        do_reset("rst_hi");
        cyc(1'b1, 6'h11, 1'b0, 1'b0);
        cyc(1'b1, 6'h11, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b1, 6'h02, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("rst_hi_bits", 32'(io_deq_bits), 32'h02);
        check("rst_hi_ext",  32'(io_deq_ext), 0);
        drain();

        // Fill and overflow.
        for (int i = 1; i <= 5; i++) push(CW'(i));
        check("fill_count", 32'(io_count), 4);
        check("fill_ovf",   32'(io_overflow), 1);
        drain();
        cyc(1'b0, '0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Full with a simultaneous dequeue.
        for (int i = 1; i <= 4; i++) push(CW'(i));
        cyc(1'b1, 6'h05, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("fulldeq_count", 32'(io_count), 4);
        check("fulldeq_ovf",   32'(io_overflow), 0);
        drain();

        // Overflow set and clear in the same cycle: set wins.
        for (int i = 1; i <= 4; i++) push(CW'(i + 8));
        cyc(1'b1, 6'h3f, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0);
        drain();

        // Asynchronous reset while draining.
        for (int i = 1; i <= 3; i++) push(CW'(6'h20 + i));
        io_deq_ready = 1'b1;
        @(posedge clk);
        void'(exp_q.pop_front());
        #3;
        do_reset("rst_mid");
        cyc(1'b0, '0, 1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), CW'($urandom_range(0, 63)),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
